// File: rtl/register_write_arbiter_pkg.sv
// Shared definitions for register_write_arbiter: FSM state encoding and an
// index-width helper used for elaboration-time parameter checks.
package register_write_arbiter_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE   = IDLE,
        STATE_GRANT  = GRANT,
        STATE_COMMIT = COMMIT
    } state_t;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/Register.sv
// Generic enabled storage register with a synchronous clear.
// areset is sampled on the clock edge like clear; callers in this design tie it low.
module Register #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             areset,
    input  logic             clear,
    input  logic             clock_enable,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (areset || clear) begin
            q <= RESET_VALUE;
        end else if (clock_enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/round_robin_select.sv
// Combinational round-robin picker: first set request bit at or above the
// pointer, wrapping at REQUESTER_COUNT. The parent registers the result.
module round_robin_select #(
    parameter int REQUESTER_COUNT = 4,
    parameter int OWNER_WIDTH     = 2
) (
    input  logic [REQUESTER_COUNT-1:0] requests,
    input  logic [OWNER_WIDTH-1:0]     pointer,
    output logic [OWNER_WIDTH-1:0]     winner,
    output logic                       any_request
);

    logic [OWNER_WIDTH:0] candidate;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        winner      = '0;
        any_request = 1'b0;
        candidate   = '0;
        for (int off = REQUESTER_COUNT - 1; off >= 0; off--) begin
            candidate = {1'b0, pointer} + (OWNER_WIDTH + 1)'(off);
            if (candidate >= (OWNER_WIDTH + 1)'(REQUESTER_COUNT)) begin
                candidate = candidate - (OWNER_WIDTH + 1)'(REQUESTER_COUNT);
            end
            if (requests[candidate[OWNER_WIDTH-1:0]]) begin
                winner      = candidate[OWNER_WIDTH-1:0];
                any_request = 1'b1;
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing one storage register between several writers.
// Define REGISTER_WRITE_ARBITER_LOCK_EN to add requests_lock for back-to-back writes.
module register_write_arbiter
    import register_write_arbiter_pkg::*;
#(
    parameter int                    WORD_WIDTH      = 8,
    parameter int                    REQUESTER_COUNT = 4,
    parameter logic [WORD_WIDTH-1:0] RESET_VALUE     = '0,
    parameter int                    OWNER_WIDTH     = 2
) (
    input  logic                                  clock,
    input  logic                                  clear,
`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
    input  logic [REQUESTER_COUNT-1:0]            requests_lock,
`endif
    input  logic [REQUESTER_COUNT-1:0]            requests_valid,
    input  logic [REQUESTER_COUNT*WORD_WIDTH-1:0] requests_data,
    output logic [REQUESTER_COUNT-1:0]            requests_ready,
    output logic [WORD_WIDTH-1:0]                 register_out,
    output logic [OWNER_WIDTH-1:0]                register_owner,
    output logic                                  register_updated
);

    if (REQUESTER_COUNT < 2) begin : g_count_check
        $error("register_write_arbiter: REQUESTER_COUNT must be 2 or more");
    end
    if (OWNER_WIDTH != clog2(REQUESTER_COUNT)) begin : g_owner_width_check
        $error("register_write_arbiter: OWNER_WIDTH must equal clog2(REQUESTER_COUNT)");
    end

    state_t                 state_reg, state_next;
    logic [OWNER_WIDTH-1:0] winner_reg, winner_next;
    logic [OWNER_WIDTH-1:0] pointer_reg, pointer_next;
    logic [OWNER_WIDTH-1:0] pointer_after_winner;
    logic [OWNER_WIDTH-1:0] select_winner;
    logic                   select_any;
    logic                   commit_enable;
    logic [WORD_WIDTH-1:0]  data_words [REQUESTER_COUNT];

    for (genvar gi = 0; gi < REQUESTER_COUNT; gi++) begin : g_unpack
        assign data_words[gi] = requests_data[gi*WORD_WIDTH +: WORD_WIDTH];
    end

    round_robin_select #(
        .REQUESTER_COUNT (REQUESTER_COUNT),
        .OWNER_WIDTH     (OWNER_WIDTH)
    ) u_select (
        .requests    (requests_valid),
        .pointer     (pointer_reg),
        .winner      (select_winner),
        .any_request (select_any)
    );

    assign pointer_after_winner = (winner_reg == OWNER_WIDTH'(REQUESTER_COUNT - 1))
                                ? '0 : winner_reg + OWNER_WIDTH'(1);

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg   <= STATE_IDLE;
            winner_reg  <= '0;
            pointer_reg <= '0;
        end else begin
            state_reg   <= state_next;
            winner_reg  <= winner_next;
            pointer_reg <= pointer_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        winner_next    = winner_reg;
        pointer_next   = pointer_reg;
        requests_ready = '0;
        commit_enable  = 1'b0;
        case (state_reg)
            STATE_IDLE: begin
                if (select_any) begin
                    winner_next = select_winner;
                    state_next  = STATE_GRANT;
                end
            end
            STATE_GRANT: begin
                requests_ready[winner_reg] = 1'b1;
                // A granted requester that dropped valid is skipped without advancing priority.
                if (requests_valid[winner_reg]) begin
                    commit_enable = 1'b1;
                    state_next    = STATE_COMMIT;
                end else begin
                    state_next = STATE_IDLE;
                end
            end
            STATE_COMMIT: begin
`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
                if (requests_lock[winner_reg] && requests_valid[winner_reg]) begin
                    state_next = STATE_GRANT;
                end else begin
                    pointer_next = pointer_after_winner;
                    state_next   = STATE_IDLE;
                end
`else
                pointer_next = pointer_after_winner;
                state_next   = STATE_IDLE;
`endif
            end
            default: begin
                state_next = STATE_IDLE;
            end
        endcase
    end

    // Storage loads on the GRANT->COMMIT edge so the new word is visible during COMMIT.
    Register #(
        .WIDTH       (WORD_WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_register_out (
        .clock        (clock),
        .areset       (1'b0),
        .clear        (clear),
        .clock_enable (commit_enable),
        .d            (data_words[winner_reg]),
        .q            (register_out)
    );

    Register #(
        .WIDTH       (OWNER_WIDTH),
        .RESET_VALUE ('0)
    ) u_register_owner (
        .clock        (clock),
        .areset       (1'b0),
        .clear        (clear),
        .clock_enable (commit_enable),
        .d            (winner_reg),
        .q            (register_owner)
    );

    assign register_updated = (state_reg == STATE_COMMIT);

endmodule

// File: tb/tb_register_write_arbiter.sv
// Scoreboard testbench for register_write_arbiter; lock scenario runs only
// when REGISTER_WRITE_ARBITER_LOCK_EN is defined.
module tb_register_write_arbiter;

    logic        clock;
    logic        clear;
    logic [3:0]  requests_valid;
    logic [31:0] requests_data;
    logic [3:0]  requests_ready;
    logic [7:0]  register_out;
    logic [1:0]  register_owner;
    logic        register_updated;
`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
    logic [3:0]  requests_lock;
`endif

    logic [7:0]  word [4];
    int          remaining [4];
    logic [9:0]  exp_q [$];
    int          checks;
    int          errors;
    int          cycle_count;
    logic [1:0]  seen_owner [8];
    int          seen_cycle [8];
    int          seen_n;

    assign requests_data = {word[3], word[2], word[1], word[0]};

    register_write_arbiter dut (
        .clock            (clock),
        .clear            (clear),
`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
        .requests_lock    (requests_lock),
`endif
        .requests_valid   (requests_valid),
        .requests_data    (requests_data),
        .requests_ready   (requests_ready),
        .register_out     (register_out),
        .register_owner   (register_owner),
        .register_updated (register_updated)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // One clock: record transfers, advance requester models, check updates against the scoreboard.
    task automatic cycle();
        logic [3:0] took;
        logic [9:0] expected;
        took = '0;
        if (!clear) took = requests_valid & requests_ready;
        for (int i = 0; i < 4; i++) begin
            if (took[i]) exp_q.push_back({2'(i), word[i]});
        end
        @(posedge clock);
        #1;
        cycle_count++;
        for (int i = 0; i < 4; i++) begin
            if (took[i]) begin
                remaining[i]--;
                if (remaining[i] <= 0) begin
                    requests_valid[i] = 1'b0;
`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
                    requests_lock[i] = 1'b0;
`endif
                end else begin
                    word[i] = word[i] + 8'd1;
                end
            end
        end
        checks++;
        if ($countones(requests_ready) > 1) begin
            errors++;
            $display("FAIL ready_onehot: got %b, required at most one bit", requests_ready);
        end
        if (register_updated) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_update: got owner=%0d data=%h, required no update",
                         register_owner, register_out);
            end else begin
                expected = exp_q.pop_front();
                $display("write owner=%0d data=%h (expected owner=%0d data=%h) at cycle %0d",
                         register_owner, register_out, expected[9:8], expected[7:0], cycle_count);
                if ({register_owner, register_out} !== expected) begin
                    errors++;
                    $display("FAIL write_value: got owner=%0d data=%h, required owner=%0d data=%h",
                             register_owner, register_out, expected[9:8], expected[7:0]);
                end
            end
        end
    endtask

    // Runs until n updates are seen (or the limit expires), logging owners and cycle numbers.
    task automatic collect(input int n, input int limit);
        seen_n = 0;
        for (int c = 0; c < limit && seen_n < n; c++) begin
            cycle();
            if (register_updated) begin
                seen_owner[seen_n] = register_owner;
                seen_cycle[seen_n] = cycle_count;
                seen_n++;
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        requests_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            word[i] = 8'hEE;
            remaining[i] = 1;
        end
        for (int k = 0; k < 2; k++) begin
            cycle();
            checks++;
            if (requests_ready !== 4'b0000 || register_out !== 8'h00 ||
                register_owner !== 2'd0 || register_updated !== 1'b0) begin
                errors++;
                $display("FAIL reset: got ready=%b out=%h owner=%0d upd=%b, required 0000/00/0/0",
                         requests_ready, register_out, register_owner, register_updated);
            end
        end
        requests_valid = 4'b0000;
        clear = 1'b0;
        cycle();
    endtask

    task automatic test_fairness();
        int exp_owner [5];
        exp_owner = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            word[i] = 8'h10 + 8'(i);
            remaining[i] = (i == 0) ? 2 : 1;
        end
        requests_valid = 4'b1111;
        collect(5, 40);
        checks++;
        if (seen_n != 5) begin
            errors++;
            $display("FAIL fairness_timeout: got %0d updates, required 5", seen_n);
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (seen_owner[k] !== 2'(exp_owner[k])) begin
                    errors++;
                    $display("FAIL fairness_owner[%0d]: got %0d, required %0d",
                             k, seen_owner[k], exp_owner[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (seen_cycle[k] - seen_cycle[k-1] != 3) begin
                        errors++;
                        $display("FAIL fairness_spacing[%0d]: got %0d cycles, required 3",
                                 k, seen_cycle[k] - seen_cycle[k-1]);
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) cycle();
    endtask

    task automatic test_single_write();
        word[2] = 8'hA5;
        remaining[2] = 1;
        requests_valid = 4'b0100;
        cycle();
        checks++;
        if (requests_ready !== 4'b0100 || register_updated !== 1'b0) begin
            errors++;
            $display("FAIL single_ready: got ready=%b upd=%b, required 0100/0",
                     requests_ready, register_updated);
        end
        cycle();
        checks++;
        if (register_updated !== 1'b1 || register_out !== 8'hA5 || register_owner !== 2'd2) begin
            errors++;
            $display("FAIL single_commit: got upd=%b out=%h owner=%0d, required 1/a5/2",
                     register_updated, register_out, register_owner);
        end
        cycle();
        checks++;
        if (register_updated !== 1'b0 || register_out !== 8'hA5 || requests_ready !== 4'b0000) begin
            errors++;
            $display("FAIL single_hold: got upd=%b out=%h ready=%b, required 0/a5/0000",
                     register_updated, register_out, requests_ready);
        end
        for (int k = 0; k < 3; k++) cycle();
        checks++;
        if (register_out !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle_hold: got out=%h, required a5", register_out);
        end
    endtask

    task automatic test_wrap_skip();
        word[0] = 8'h20;
        word[1] = 8'h21;
        remaining[0] = 1;
        remaining[1] = 1;
        requests_valid = 4'b0011;
        collect(2, 20);
        checks++;
        if (seen_n != 2 || seen_owner[0] !== 2'd0 || seen_owner[1] !== 2'd1) begin
            errors++;
            $display("FAIL wrap_order: got n=%0d owners=%0d,%0d, required 2 owners=0,1",
                     seen_n, seen_owner[0], seen_owner[1]);
        end
        for (int k = 0; k < 2; k++) cycle();
        word[0] = 8'h30;
        word[3] = 8'h33;
        remaining[0] = 1;
        remaining[3] = 1;
        requests_valid = 4'b1001;
        collect(2, 20);
        checks++;
        if (seen_n != 2 || seen_owner[0] !== 2'd3 || seen_owner[1] !== 2'd0) begin
            errors++;
            $display("FAIL skip_order: got n=%0d owners=%0d,%0d, required 2 owners=3,0",
                     seen_n, seen_owner[0], seen_owner[1]);
        end
        for (int k = 0; k < 2; k++) cycle();
    endtask

    task automatic test_clear_mid_transfer();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        cycle();
        word[1] = 8'h77;
        remaining[1] = 1;
        requests_valid = 4'b0010;
        cycle();
        checks++;
        if (requests_ready !== 4'b0010) begin
            errors++;
            $display("FAIL clear_pre_grant: got ready=%b, required 0010", requests_ready);
        end
        clear = 1'b1;
        cycle();
        checks++;
        if (register_updated !== 1'b0 || register_out !== 8'h00 ||
            register_owner !== 2'd0 || requests_ready !== 4'b0000) begin
            errors++;
            $display("FAIL clear_mid: got upd=%b out=%h owner=%0d ready=%b, required 0/00/0/0000",
                     register_updated, register_out, register_owner, requests_ready);
        end
        clear = 1'b0;
        word[0] = 8'h55;
        remaining[0] = 1;
        requests_valid = 4'b0011;
        collect(2, 20);
        checks++;
        if (seen_n != 2 || seen_owner[0] !== 2'd0 || seen_owner[1] !== 2'd1) begin
            errors++;
            $display("FAIL clear_pointer: got n=%0d owners=%0d,%0d, required 2 owners=0,1",
                     seen_n, seen_owner[0], seen_owner[1]);
        end
        for (int k = 0; k < 2; k++) cycle();
    endtask

`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
    task automatic test_lock();
        int exp_owner [4];
        int exp_gap [4];
        exp_owner = '{1, 1, 1, 0};
        exp_gap   = '{0, 2, 2, 3};
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        word[1] = 8'h41;
        remaining[1] = 3;
        requests_lock = 4'b0010;
        requests_valid = 4'b0010;
        cycle();
        word[0] = 8'h40;
        remaining[0] = 1;
        requests_valid[0] = 1'b1;
        collect(4, 30);
        checks++;
        if (seen_n != 4) begin
            errors++;
            $display("FAIL lock_timeout: got %0d updates, required 4", seen_n);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (seen_owner[k] !== 2'(exp_owner[k]) ||
                    (k > 0 && seen_cycle[k] - seen_cycle[k-1] != exp_gap[k])) begin
                    errors++;
                    $display("FAIL lock_seq[%0d]: got owner=%0d gap=%0d, required owner=%0d gap=%0d",
                             k, seen_owner[k], (k > 0) ? seen_cycle[k] - seen_cycle[k-1] : 0,
                             exp_owner[k], exp_gap[k]);
                end
            end
        end
        for (int k = 0; k < 3; k++) cycle();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        cycle_count = 0;
        clear = 1'b1;
        requests_valid = 4'b0000;
`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
        requests_lock = 4'b0000;
`endif
        for (int i = 0; i < 4; i++) begin
            word[i] = 8'h00;
            remaining[i] = 0;
        end
        test_reset();
        test_fairness();
        test_single_write();
        test_wrap_skip();
        test_clear_mid_transfer();
`ifdef REGISTER_WRITE_ARBITER_LOCK_EN
        test_lock();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending writes, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares one WORD_WIDTH storage register between REQUESTER_COUNT writers, each with a valid/ready write port.
- Grants with registered round-robin priority, commits the winning word and reports the last writer's index.
- Sits in front of configuration and status registers that several control blocks must update.

Parameters:
- WORD_WIDTH, 8, width of the stored word and of each requester's data.
- REQUESTER_COUNT, 4, number of write ports; must be 2 or more.
- RESET_VALUE, 0, value of the stored word after clear.
- OWNER_WIDTH, 2, index width; must equal clog2(REQUESTER_COUNT). Checked by assertion.

Ports:
- clock  input  1  single clock; all state changes on its rising edge.
- clear  input  1  synchronous, active-high reset; takes priority over every other input.
- requests_valid  input  REQUESTER_COUNT  bit i: requester i offers a word.
- requests_data  input  REQUESTER_COUNT*WORD_WIDTH  word i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- requests_ready  output  REQUESTER_COUNT  one-hot or zero; a transfer on bit i occurs when valid[i] and ready[i] are both high.
- register_out  output  WORD_WIDTH  stored word.
- register_owner  output  OWNER_WIDTH  index of the requester that wrote register_out.
- register_updated  output  1  one-cycle pulse, aligned with the new register_out value.

Behaviour:
- Reset values:
  - register_out = RESET_VALUE.
  - register_owner = 0.
  - register_updated = 0.
  - requests_ready = 0.
  - priority pointer = 0.
  - state = IDLE.
- State IDLE:
  - If any valid bit is high, pick the first high bit at or above the pointer, wrapping at REQUESTER_COUNT.
  - Register the winner's index and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT:
  - requests_ready[winner] = 1 for exactly this cycle.
  - If valid[winner] is high, capture data[winner] and go to COMMIT.
  - If valid[winner] is low, a protocol violation has occurred. Return to IDLE with no write and leave the pointer unchanged.
- State COMMIT:
  - register_out takes the captured word and register_owner takes the winner's index.
  - register_updated = 1.
  - pointer = winner+1, wrapping REQUESTER_COUNT-1 to 0.
  - Go to IDLE.
- Latency: valid rising in cycle t gives ready in t+1 and register_out/register_updated visible from t+2.
- Throughput: one write per 3 cycles.
- Protocol rule: a requester holds valid and data stable until it sees ready.
- Only the granted requester sees ready. All others wait regardless of valid.
- Fairness: with all requesters asserting, grants go 0,1,2,3,0,... and none waits more than REQUESTER_COUNT grants.
- A requester that asserts valid while a transfer is in progress is considered at the next IDLE.
- clear at any point, including mid-GRANT or mid-COMMIT:
  - the next cycle shows the full reset values;
  - the pending write is discarded and no register_updated pulse is produced.
- When no write occurs, register_out holds its value indefinitely.

Optional Feature:
- Macro: REGISTER_WRITE_ARBITER_LOCK_EN.
- When defined:
  - Adds input requests_lock, REQUESTER_COUNT bits.
  - If lock[winner] and valid[winner] are high during COMMIT, the next state is GRANT for the same winner and the pointer is not advanced. This gives back-to-back writes every 2 cycles.
  - Releasing lock, or dropping valid, resumes round-robin with pointer = winner+1.
  - clear also ends any lock.
- When undefined:
  - The port is absent.
  - Behaviour is exactly as above with no lock logic.

Decomposition:
- Shared package/header register_write_arbiter_pkg holds:
  - state encoding localparams: IDLE=2'd0, GRANT=2'd1, COMMIT=2'd2;
  - a clog2 function for index widths.
- Storage uses the team's existing Register module instances for register_out and register_owner:
  - clock_enable driven by COMMIT;
  - clear driven by clear;
  - areset tied low.
- One new sub-module, round_robin_select: REQUESTER_COUNT request bits and pointer in, winner index and any-request out. Purely combinational; the parent registers its outputs.

Test Plan:
- Reset: assert clear for 2 cycles with valid=4'b1111 -> ready=0, register_out=0, register_owner=0, register_updated=0 throughout.
- Single write: valid=4'b0100, data2=8'hA5 at t -> ready=4'b0100 at t+1, register_out=8'hA5, register_owner=2, register_updated=1 at t+2 only.
- Fairness: all valid held, distinct data 8'h10..8'h13 -> owners 0,1,2,3,0 on successive updated pulses, 3 cycles apart.
- Wrap and skip: pointer=3 after a grant to 2, valid=4'b0011 -> grant 0 then 1. Requester 3's later request is granted before 0's repeat.
- Clear mid-transfer: clear asserted in GRANT for requester 1 with data 8'h77 -> no updated pulse, register_out stays RESET_VALUE, and the next grant starts from pointer 0.
- Lock (REGISTER_WRITE_ARBITER_LOCK_EN): requester 1 holds valid and lock for 3 words with valid=4'b0011 -> three consecutive updates owner=1 two cycles apart. Then lock drops -> owner 2 would be next; with only 0 valid, owner 0.
